// File: rtl/min_reduce_pkg.sv
// -----------------------------------------------------------------------------
// min_reduce_pkg
// Shared definitions for the sequential minimum/argmin reducer:
//   - state_t     : reducer FSM state encoding (IDLE, ACC, DONE)
//   - DEF_WIDTH   : default operand width in bits
//   - DEF_IDX_WIDTH : default element index width in bits
// -----------------------------------------------------------------------------
package min_reduce_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_IDX_WIDTH = 8;

    // IDLE: nothing held, ACC: partial minimum held, DONE: result waiting.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : min_reduce_pkg

// File: rtl/gt_uint_nbit.sv
// -----------------------------------------------------------------------------
// gt_uint_nbit
// Unsigned greater-than comparator: Y = (A > B).
// Parameters:
//   WIDTH     : operand width in bits
//   IMPL_TYPE : 0 = behavioural relational operator,
//               otherwise = bit-serial scan where the most significant
//               differing bit decides the result
// Ports:
//   A [WIDTH-1:0] : left operand (input)
//   B [WIDTH-1:0] : right operand (input)
//   Y             : 1 when A is strictly greater than B (output)
// -----------------------------------------------------------------------------
module gt_uint_nbit #(
    parameter int WIDTH     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Y
);

    generate
        if (IMPL_TYPE == 0) begin : g_behav
            // Relational operator; the synthesis tool picks the structure.
            always_comb begin
                Y = (A > B);
            end
        end else begin : g_scan
            // Scan LSB to MSB; a higher differing bit overrides a lower one,
            // so the final value reflects the most significant difference.
            always_comb begin
                Y = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (A[i] != B[i]) begin
                        Y = A[i];
                    end else begin
                        Y = Y;
                    end
                end
            end
        end
    endgenerate

endmodule : gt_uint_nbit

// File: rtl/min_reduce_seq.sv
// -----------------------------------------------------------------------------
// min_reduce_seq
// Streams a vector of unsigned elements (valid/ready in, last marks the end)
// and produces its minimum and the zero-based index of the first occurrence
// of that minimum (valid/ready out). One result per vector, latency 1 cycle
// after the last beat. Holds the result until the consumer accepts it; no new
// elements are accepted meanwhile.
//
// Optional feature macro: MIN_REDUCE_ARGMIN_EN
//   defined   : index/count registers present, out_idx reports the argmin
//               (index wraps modulo 2^IDX_WIDTH)
//   undefined : no index tracking, out_idx is tied to 0
//
// Parameters: WIDTH (operand bits), IDX_WIDTH (index bits),
//             IMPL_TYPE (comparator implementation select)
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   element valid
//   in_ready  out  element accepted this cycle when in_valid=1
//   in_data   in   element value [WIDTH]
//   in_last   in   element is the last of the vector
//   out_valid out  result valid
//   out_ready in   consumer accepts result
//   out_min   out  minimum of the vector [WIDTH]
//   out_idx   out  index of the minimum [IDX_WIDTH]
// -----------------------------------------------------------------------------
module min_reduce_seq
    import min_reduce_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int IDX_WIDTH = DEF_IDX_WIDTH,
    parameter int IMPL_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_min,
    output logic [IDX_WIDTH-1:0] out_idx
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] w_min_nxt;
    logic             w_replace;
    logic             w_beat;
    logic             w_take;

    // Strict compare: a tie leaves the earlier element in place.
    gt_uint_nbit #(
        .WIDTH     (WIDTH),
        .IMPL_TYPE (IMPL_TYPE)
    ) u_gt (
        .A (r_min),
        .B (in_data),
        .Y (w_replace)
    );

    // Handshake qualifiers: readiness is purely a state decode.
    always_comb begin
        w_beat = in_valid && (r_state != DONE);
        // The first element of a vector always loads; later ones only if smaller.
        w_take = w_beat && ((r_state == IDLE) || w_replace);
    end

    // Next-state logic of the reducer FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_beat) begin
                    w_state_nxt = in_last ? DONE : ACC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACC: begin
                if (w_beat && in_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = ACC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Next value of the running minimum.
    always_comb begin
        w_min_nxt = r_min;
        if (w_take) begin
            w_min_nxt = in_data;
        end else begin
            w_min_nxt = r_min;
        end
    end

    // State and minimum registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_min   <= {WIDTH{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_min   <= w_min_nxt;
        end
    end

`ifdef MIN_REDUCE_ARGMIN_EN
    logic [IDX_WIDTH-1:0] r_idx;
    logic [IDX_WIDTH-1:0] r_cnt;
    logic [IDX_WIDTH-1:0] w_idx_nxt;
    logic [IDX_WIDTH-1:0] w_cnt_nxt;

    // Index tracking: count is the position of the element being offered;
    // it wraps naturally at 2^IDX_WIDTH.
    always_comb begin
        w_idx_nxt = r_idx;
        w_cnt_nxt = r_cnt;
        if (w_beat && (r_state == IDLE)) begin
            w_idx_nxt = {IDX_WIDTH{1'b0}};
            w_cnt_nxt = IDX_WIDTH'(1);
        end else if (w_beat) begin
            w_idx_nxt = w_replace ? r_cnt : r_idx;
            w_cnt_nxt = r_cnt + IDX_WIDTH'(1);
        end else begin
            w_idx_nxt = r_idx;
            w_cnt_nxt = r_cnt;
        end
    end

    // Index and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= {IDX_WIDTH{1'b0}};
            r_cnt <= {IDX_WIDTH{1'b0}};
        end else begin
            r_idx <= w_idx_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Index output straight from its register.
    always_comb begin
        out_idx = r_idx;
    end
`else
    // Without index tracking the index output is tied low.
    always_comb begin
        out_idx = {IDX_WIDTH{1'b0}};
    end
`endif

    // Outputs are decodes of registered state or register values.
    always_comb begin
        in_ready  = (r_state != DONE);
        out_valid = (r_state == DONE);
        out_min   = r_min;
    end

endmodule : min_reduce_seq

// File: tb/tb_min_reduce_seq.sv
// -----------------------------------------------------------------------------
// tb_min_reduce_seq
// Self-checking bench for min_reduce_seq. A reference model tracks min/argmin
// as beats are accepted and pushes the expected result on the last beat; the
// scenario tasks pop and compare when the DUT presents a result.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_min_reduce_seq;

    localparam int W  = 8;
    localparam int IW = 2;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_min;
    logic [IW-1:0] out_idx;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [W+IW-1:0] exp_q[$];
    logic [W-1:0]    m_min;
    logic [IW-1:0]   m_idx;
    logic [IW-1:0]   m_cnt;
    bit              m_empty = 1'b1;

    min_reduce_seq #(
        .WIDTH     (W),
        .IDX_WIDTH (IW),
        .IMPL_TYPE (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min   (out_min),
        .out_idx   (out_idx)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [IW-1:0] exp_idx(input logic [IW-1:0] idx);
`ifdef MIN_REDUCE_ARGMIN_EN
        return idx;
`else
        return {IW{1'b0}};
`endif
    endfunction

    // Offer one element after 'gap' idle cycles, wait (bounded) for acceptance.
    task automatic send_beat(input logic [W-1:0] d, input bit last, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (m_empty) begin
                m_min   = d;
                m_idx   = '0;
                m_cnt   = IW'(1);
                m_empty = 1'b0;
            end else begin
                if (m_min > d) begin
                    m_min = d;
                    m_idx = m_cnt;
                end
                m_cnt = m_cnt + IW'(1);
            end
            if (last) begin
                exp_q.push_back({m_min, exp_idx(m_idx)});
                m_empty = 1'b1;
            end
        end
    endtask

    // Bounded wait for out_valid at a falling edge.
    task automatic wait_valid(output bit ok);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        in_data   = 8'h11;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, in_ready, out_min, out_idx} !== {1'b0, 1'b1, {W{1'b0}}, {IW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: valid=%0b ready=%0b min=%0h idx=%0d required 0 1 0 0",
                     out_valid, in_ready, out_min, out_idx);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_basic();
        logic [W+IW-1:0] e;
        out_ready = 1'b1;
        send_beat(8'd9, 1'b0, 0);
        send_beat(8'd3, 1'b0, 0);
        send_beat(8'd7, 1'b0, 0);
        send_beat(8'd3, 1'b1, 0);
        // Result must be present in the very cycle after the last beat.
        e = exp_q.pop_front();
        checks++;
        if ({out_valid, in_ready, out_min, out_idx} !== {1'b1, 1'b0, e}) begin
            errors++;
            $display("FAIL basic_result: valid=%0b ready=%0b min=%0d idx=%0d required 1 0 %0d %0d",
                     out_valid, in_ready, out_min, out_idx, e[W+IW-1:IW], e[IW-1:0]);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL basic_release: valid=%0b ready=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_single();
        logic [W+IW-1:0] e;
        out_ready = 1'b0;
        send_beat(8'hFF, 1'b1, 0);
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, in_ready, out_min, out_idx} !== {1'b1, 1'b0, e}) begin
                errors++;
                $display("FAIL single_hold[%0d]: valid=%0b ready=%0b min=%0h idx=%0d required 1 0 %0h %0d",
                         i, out_valid, in_ready, out_min, out_idx, e[W+IW-1:IW], e[IW-1:0]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL single_release: valid=%0b ready=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_stall();
        logic [W+IW-1:0] e;
        bit ok;
        out_ready = 1'b0;
        send_beat(8'd5,  1'b0, 0);
        send_beat(8'd0,  1'b0, 2);
        send_beat(8'h80, 1'b1, 1);
        wait_valid(ok);
        e = exp_q.pop_front();
        // An element offered during the stall must be ignored.
        in_valid = 1'b1;
        in_data  = 8'h01;
        in_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_valid, in_ready, out_min, out_idx} !== {1'b1, 1'b0, e}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%0b ready=%0b min=%0d idx=%0d required 1 0 %0d %0d",
                         i, out_valid, in_ready, out_min, out_idx, e[W+IW-1:IW], e[IW-1:0]);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL stall_release: valid=%0b ready=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [W+IW-1:0] e;
        bit ok;
        out_ready = 1'b1;
        send_beat(8'd8, 1'b0, 0);
        send_beat(8'd6, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        m_empty = 1'b1;
        checks++;
        if ({out_valid, in_ready, out_min, out_idx} !== {1'b0, 1'b1, {W{1'b0}}, {IW{1'b0}}}) begin
            errors++;
            $display("FAIL midreset_state: valid=%0b ready=%0b min=%0d idx=%0d required 0 1 0 0",
                     out_valid, in_ready, out_min, out_idx);
        end
        send_beat(8'd4, 1'b0, 0);
        send_beat(8'd2, 1'b1, 0);
        wait_valid(ok);
        e = exp_q.pop_front();
        checks++;
        if ({ok, out_min, out_idx} !== {1'b1, e}) begin
            errors++;
            $display("FAIL midreset_result: valid=%0b min=%0d idx=%0d required 1 %0d %0d",
                     ok, out_min, out_idx, e[W+IW-1:IW], e[IW-1:0]);
        end
        @(negedge clk);
        // Pending result discarded by reset; reset beats a simultaneous beat.
        out_ready = 1'b0;
        send_beat(8'd3, 1'b1, 0);
        e = exp_q.pop_back();
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        in_data   = 8'd7;
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, out_min} !== {1'b0, 1'b1, {W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_priority: valid=%0b ready=%0b min=%0d required 0 1 0",
                     out_valid, in_ready, out_min);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] va[6] = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd1, 8'd9};
        logic [W-1:0] vb[6] = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd3};
        logic [W+IW-1:0] e;
        bit ok;
        out_ready = 1'b1;
        for (int v = 0; v < 2; v++) begin
            for (int k = 0; k < 6; k++) begin
                send_beat((v == 0) ? va[k] : vb[k], k == 5, 0);
            end
            wait_valid(ok);
            e = exp_q.pop_front();
            checks++;
            if ({ok, out_min, out_idx} !== {1'b1, e}) begin
                errors++;
                $display("FAIL wrap[%0d]: valid=%0b min=%0d idx=%0d required 1 %0d %0d",
                         v, ok, out_min, out_idx, e[W+IW-1:IW], e[IW-1:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int v = 0; v < 8; v++) begin
                    int len;
                    len = int'($urandom_range(1, 7));
                    for (int k = 0; k < len; k++) begin
                        send_beat(W'($urandom_range(0, 15)), k == len - 1, 0);
                    end
                end
            end
            begin
                int cyc = 0;
                logic [W+IW-1:0] e;
                while (got < 8 && cyc < 600) begin
                    @(negedge clk);
                    #1;
                    cyc++;
                    if (out_valid) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL b2b_unexpected: min=%0d idx=%0d required no result",
                                     out_min, out_idx);
                        end else begin
                            e = exp_q.pop_front();
                            if ({in_ready, out_min, out_idx} !== {1'b0, e}) begin
                                errors++;
                                $display("FAIL b2b_result[%0d]: ready=%0b min=%0d idx=%0d required 0 %0d %0d",
                                         got, in_ready, out_min, out_idx, e[W+IW-1:IW], e[IW-1:0]);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        @(negedge clk);
        checks++;
        if (got != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: results=%0d pending=%0d required 8 0", got, exp_q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_single();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_min_reduce_seq

// File: doc/min_reduce_seq.md
MIN_REDUCE_SEQ -- requirements
Module: min_reduce_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: operand width in bits.
REQ-002 The module SHALL have parameter IDX_WIDTH, default 8: element index width.
REQ-003 The module SHALL have parameter IMPL_TYPE, default 0: comparator implementation select, passed unchanged to the comparator.
REQ-004 The module SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 The module SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 The module SHALL have port in_valid, input, 1: the input element is valid.
REQ-007 The module SHALL have port in_ready, output, 1: the block accepts an element this cycle.
REQ-008 The module SHALL have port in_data, input, WIDTH: unsigned element.
REQ-009 The module SHALL have port in_last, input, 1: the element is the last of the current vector.
REQ-010 The module SHALL have port out_valid, output, 1: result valid.
REQ-011 The module SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 The module SHALL have port out_min, output, WIDTH: minimum of the vector.
REQ-013 The module SHALL have port out_idx, output, IDX_WIDTH: zero-based index of the minimum.

Function
REQ-014 An element SHALL be accepted ("beat") only in a cycle where in_valid=1 and in_ready=1.
REQ-015 The FSM SHALL have exactly three states: IDLE (no element held), ACC (at least one element held), DONE (result held).
REQ-016 in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE; in_ready SHALL NOT depend on in_valid.
REQ-017 A beat in IDLE SHALL load min<=in_data, idx<=0, count<=1, and move the FSM to ACC (or to DONE if in_last=1).
REQ-018 A beat in ACC SHALL replace min with in_data and idx with count only when min > in_data (strict); count SHALL then increment.
REQ-019 Ties SHALL keep the earlier index.
REQ-020 A beat with in_last=1 in ACC SHALL apply REQ-018 and then move the FSM to DONE.
REQ-021 out_valid SHALL be 1 exactly while in DONE, so it rises in the cycle after the last beat (latency 1).
REQ-022 out_min and out_idx SHALL be stable while out_valid=1.
REQ-023 With out_valid=1 and out_ready=1, the FSM SHALL move to IDLE in the next cycle; the next vector's first beat SHALL be accepted no earlier than that cycle.
REQ-024 count SHALL wrap modulo 2^IDX_WIDTH; the reported index is the wrapped value, and min remains correct for any vector length.
REQ-025 A cycle with in_valid=0 in ACC SHALL hold all state.
REQ-026 The comparison SHALL be purely combinational on the registered min and in_data; no additional pipeline stage.

Reset
REQ-027 When rst=1 at a clock edge, state SHALL become IDLE, and min, idx and count SHALL become 0.
REQ-028 After reset, out_valid SHALL be 0, in_ready SHALL be 1, and out_min and out_idx SHALL be 0.
REQ-029 A reset in ACC or DONE SHALL discard the partial or pending result without emitting it.
REQ-030 Reset SHALL take priority over a simultaneous beat or result handshake.

Configuration
REQ-031 With macro MIN_REDUCE_ARGMIN_EN defined, the idx register, the count register and REQ-018/REQ-024 index tracking SHALL be implemented.
REQ-032 With MIN_REDUCE_ARGMIN_EN undefined, the idx and count registers SHALL be omitted, out_idx SHALL be driven constant 0, and all other behaviour SHALL be identical.

Structure
REQ-033 Package min_reduce_pkg SHALL hold the FSM state enum (IDLE, ACC, DONE) and the default WIDTH/IDX_WIDTH constants.
REQ-034 The comparison SHALL be one instance of the existing gt_uint_nbit comparator (A=min register, B=in_data, Y=replace), parameterised by WIDTH and IMPL_TYPE; there SHALL be no other sub-module.

Verification
REQ-035 Vector {9,3,7,3} with last on the 4th beat and out_ready=1 -> out_valid 1 cycle later, out_min=3, out_idx=1.
REQ-036 Single beat 0xFF with in_last=1 -> out_min=0xFF, out_idx=0; in_ready=0 until out_ready handshake.
REQ-037 Vector {5,0,0x80} with in_valid gaps and out_ready held 0 for 4 cycles -> result stable (0, idx 1) throughout and in_ready=0; IDLE after handshake.
REQ-038 rst asserted after 2 of 4 beats -> no out_valid; new vector {4,2} -> out_min=2, out_idx=1.
REQ-039 With IDX_WIDTH=2, 6 beats {9,9,9,9,1,9} -> out_min=1, out_idx=0 (wrap); with the macro undefined, the same vector gives out_idx=0 and out_min=1.
